// File: rtl/ex_mac.sv
// EX-stage multiply / multiply-accumulate unit.
// MUL/MULT/MULTU finish in one cycle; MADD-class ops spend one extra cycle in ACC.
module ex_mac #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_hold_i,
  input  logic          flush_i,
  input  logic [7:0]    aluop_i,
  input  logic [DW-1:0] reg1_i,
  input  logic [DW-1:0] reg2_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic [DW-1:0] mul_res_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          whilo_o,
  output logic          stallreq_o
);

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t          state;
  logic [2*DW-1:0] prod_q;
  logic [7:0]      op_q;

  logic            is_mul;
  logic            is_mult;
  logic            is_macc;
  logic            op_signed;

  always_comb begin
    is_mul    = 1'b0;
    is_mult   = 1'b0;
    is_macc   = 1'b0;
    op_signed = 1'b0;
    case (aluop_i)
      EXE_MUL_OP: begin
        is_mul    = 1'b1;
        op_signed = 1'b1;
      end
      EXE_MULT_OP: begin
        is_mult   = 1'b1;
        op_signed = 1'b1;
      end
      EXE_MULTU_OP: is_mult = 1'b1;
      EXE_MADD_OP, EXE_MSUB_OP: begin
        is_macc   = 1'b1;
        op_signed = 1'b1;
      end
      EXE_MADDU_OP, EXE_MSUBU_OP: is_macc = 1'b1;
      default: ;
    endcase
  end

  // Sign-magnitude multiply: negate negative operands, fix sign after.
  logic            a_neg;
  logic            b_neg;
  logic [DW-1:0]   a_mag;
  logic [DW-1:0]   b_mag;
  logic [2*DW-1:0] prod_u;
  logic [2*DW-1:0] prod;

  always_comb begin
    a_neg  = op_signed & reg1_i[DW-1];
    b_neg  = op_signed & reg2_i[DW-1];
    a_mag  = a_neg ? ('0 - reg1_i) : reg1_i;
    b_mag  = b_neg ? ('0 - reg2_i) : reg2_i;
    prod_u = {{DW{1'b0}}, a_mag} * {{DW{1'b0}}, b_mag};
    prod   = (a_neg ^ b_neg) ? ('0 - prod_u) : prod_u;
  end

  logic            acc_sub;
  logic [2*DW-1:0] acc;

  always_comb begin
    acc_sub = (op_q == EXE_MSUB_OP) || (op_q == EXE_MSUBU_OP);
    acc     = acc_sub ? ({hi_i, lo_i} - prod_q)
                      : ({hi_i, lo_i} + prod_q);
  end

  always_comb begin
    mul_res_o  = '0;
    hi_o       = '0;
    lo_o       = '0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (is_mul) mul_res_o = prod[DW-1:0];
          if (is_mult) begin
            {hi_o, lo_o} = prod;
            whilo_o      = ~flush_i;
          end
          if (is_macc) stallreq_o = 1'b1;
        end
        ACC: begin
          {hi_o, lo_o} = acc;
          whilo_o      = ~flush_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prod_q <= '0;
      op_q   <= EXE_NOP_OP;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // Capture regardless of ex_hold_i: stall keeps operands stable.
          if (is_macc) begin
            prod_q <= prod;
            op_q   <= aluop_i;
            state  <= ACC;
          end
        end
        ACC: begin
          if (!ex_hold_i) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mac.sv
// Directed bench for ex_mac: vector table for single-cycle ops,
// hand sequences for MADD-class stall, hold, flush and reset.
module tb_ex_mac;

  localparam logic [7:0] NOP   = 8'b0000_0000;
  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] MUL   = 8'b1010_1001;
  localparam logic [7:0] MADD  = 8'b1010_0110;
  localparam logic [7:0] MADDU = 8'b1010_1000;
  localparam logic [7:0] MSUB  = 8'b1010_1010;
  localparam logic [7:0] OR_OP = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_hold_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] mul_res_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mac #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_hold_i (ex_hold_i),
    .flush_i   (flush_i),
    .aluop_i   (aluop_i),
    .reg1_i    (reg1_i),
    .reg2_i    (reg2_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .mul_res_o (mul_res_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .whilo_o   (whilo_o),
    .stallreq_o(stallreq_o)
  );

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        chk_mul;
    logic [31:0] mul;
    logic        chk_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        stall;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h,
                       input logic [31:0] l);
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
    hi_i    = h;
    lo_i    = l;
  endtask

  task automatic chk_acc(input string tag, input logic [31:0] h,
                         input logic [31:0] l, input logic w,
                         input logic s);
    check({tag, ".hi"}, hi_o, h);
    check({tag, ".lo"}, lo_o, l);
    check({tag, ".whilo"}, {31'b0, whilo_o}, {31'b0, w});
    check({tag, ".stall"}, {31'b0, stallreq_o}, {31'b0, s});
  endtask

  initial begin
    vecs[0] = '{"mult_neg", MULT, 32'hFFFFFFFE, 32'd3,
                0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0};
    vecs[1] = '{"multu_big", MULTU, 32'hFFFFFFFE, 32'd3,
                0, 0, 1, 32'h00000002, 32'hFFFFFFFA, 1, 0};
    vecs[2] = '{"multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                0, 0, 1, 32'hFFFFFFFE, 32'h00000001, 1, 0};
    vecs[3] = '{"mult_minmin", MULT, 32'h80000000, 32'h80000000,
                0, 0, 1, 32'h40000000, 32'h00000000, 1, 0};
    vecs[4] = '{"mul_min2", MUL, 32'h80000000, 32'd2,
                1, 32'h00000000, 0, 0, 0, 0, 0};
    vecs[5] = '{"mul_neg", MUL, 32'd7, 32'hFFFFFFFD,
                1, 32'hFFFFFFEB, 0, 0, 0, 0, 0};
    vecs[6] = '{"mul_pos", MUL, 32'h1234, 32'h100,
                1, 32'h00123400, 0, 0, 0, 0, 0};
    vecs[7] = '{"nop", NOP, 32'h5, 32'h6,
                1, 0, 1, 0, 0, 0, 0};
    vecs[8] = '{"or_op", OR_OP, 32'hFFFF, 32'h3,
                1, 0, 1, 0, 0, 0, 0};

    rst = 1'b1;
    ex_hold_i = 1'b0;
    flush_i = 1'b0;
    drive(MULT, 32'h7, 32'h9, 32'h1, 32'h2);
    tick();
    tick();
    sample();
    chk_acc("reset", 0, 0, 0, 0);
    check("reset.mul", mul_res_o, 0);
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 32'hAAAA, 32'h5555);
      sample();
      if (vecs[i].chk_mul) check({vecs[i].name, ".mul"}, mul_res_o, vecs[i].mul);
      if (vecs[i].chk_hilo) begin
        check({vecs[i].name, ".hi"}, hi_o, vecs[i].hi);
        check({vecs[i].name, ".lo"}, lo_o, vecs[i].lo);
      end
      check({vecs[i].name, ".whilo"}, {31'b0, whilo_o}, {31'b0, vecs[i].whilo});
      check({vecs[i].name, ".stall"}, {31'b0, stallreq_o}, {31'b0, vecs[i].stall});
      tick();
    end

    // MADDU: 0xFFFFFFFF*2 + 1
    drive(MADDU, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1);
    sample();
    chk_acc("maddu.c1", 0, 0, 0, 1);
    tick();
    drive(MULT, 32'h3, 32'h3, 32'd0, 32'd1);
    sample();
    chk_acc("maddu.c2", 32'd1, 32'hFFFFFFFF, 1, 0);
    tick();
    drive(NOP, 0, 0, 0, 0);
    sample();
    chk_acc("maddu.idle", 0, 0, 0, 0);
    tick();

    // MSUB: 5 - 2*3 = -1
    drive(MSUB, 32'd2, 32'd3, 32'd0, 32'd5);
    sample();
    chk_acc("msub.c1", 0, 0, 0, 1);
    tick();
    drive(NOP, 0, 0, 32'd0, 32'd5);
    sample();
    chk_acc("msub.c2", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    tick();

    // MSUB held three cycles in ACC; foreign aluop must be ignored
    drive(MSUB, 32'd2, 32'd3, 32'd0, 32'd5);
    sample();
    chk_acc("msubh.c1", 0, 0, 0, 1);
    tick();
    ex_hold_i = 1'b1;
    drive(MULT, 32'h11, 32'h22, 32'd0, 32'd5);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk_acc($sformatf("msubh.hold%0d", k), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
      tick();
    end
    ex_hold_i = 1'b0;
    sample();
    chk_acc("msubh.rel", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    tick();
    drive(MULT, 32'd3, 32'd4, 0, 0);
    sample();
    chk_acc("msubh.after", 0, 32'd12, 1, 0);
    tick();

    // Back-to-back MADD, HI/LO forwarded
    drive(MADD, 32'h10, 32'h10, 0, 0);
    sample();
    chk_acc("b2b.c1", 0, 0, 0, 1);
    tick();
    sample();
    chk_acc("b2b.c2", 0, 32'h100, 1, 0);
    tick();
    drive(MADD, 32'h10, 32'h10, 0, 32'h100);
    sample();
    chk_acc("b2b.c3", 0, 0, 0, 1);
    tick();
    sample();
    chk_acc("b2b.c4", 0, 32'h200, 1, 0);
    tick();

    // Flush in ACC
    drive(MADD, 32'h10, 32'h10, 0, 0);
    sample();
    chk_acc("flush.c1", 0, 0, 0, 1);
    tick();
    flush_i = 1'b1;
    ex_hold_i = 1'b1;
    sample();
    check("flush.whilo", {31'b0, whilo_o}, 0);
    check("flush.stall", {31'b0, stallreq_o}, 0);
    tick();
    flush_i = 1'b0;
    ex_hold_i = 1'b0;
    drive(MULT, 32'd3, 32'd4, 0, 0);
    sample();
    chk_acc("flush.mult", 0, 32'd12, 1, 0);
    tick();

    // Reset in ACC
    drive(MADD, 32'h10, 32'h10, 0, 0);
    sample();
    chk_acc("rstacc.c1", 0, 0, 0, 1);
    tick();
    rst = 1'b1;
    sample();
    chk_acc("rstacc.c2", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(MUL, 32'h80000000, 32'd2, 32'h1, 32'h1);
    sample();
    check("rstacc.mul", mul_res_o, 0);
    check("rstacc.whilo", {31'b0, whilo_o}, 0);
    check("rstacc.stall", {31'b0, stallreq_o}, 0);
    tick();
    drive(MULT, 32'd5, 32'd5, 0, 0);
    sample();
    chk_acc("rstacc.mult", 0, 32'd25, 1, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
